// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared SPI types and defaults: transfer state enum, default width.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_DEFAULT_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEAD   = 3'd1,
        XFER   = 3'd2,
        TRAIL  = 3'd3,
        FINISH = 3'd4
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module   : spi_shift_engine
// Purpose  : SPI master shift engine (modes 0-3), paced by an external
//            half-period strobe. Optional macro SPI_LSB_FIRST_EN adds lsbFirst.
// Revision : 1.0 - initial release
// ============================================================================
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] txData,
    input  logic              cpol,
    input  logic              cpha,
`ifdef SPI_LSB_FIRST_EN
    input  logic              lsbFirst,
`endif
    input  logic              SCLKTick,
    output logic              prescaleEn,
    input  logic              MISO,
    output logic              SCLK,
    output logic              MOSI,
    output logic              CS_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rxData
);

    localparam int                   c_CNT_W     = $clog2(2 * DATA_W) + 1;
    localparam logic [c_CNT_W-1:0]   c_LAST_EDGE = c_CNT_W'(2 * DATA_W);

    spi_state_t          r_state;
    spi_state_t          w_next_state;
    logic                r_sclk;
    logic                r_mosi;
    logic                r_cpol;
    logic                r_cpha;
    logic [c_CNT_W-1:0]  r_edge_cnt;
    logic [c_CNT_W-1:0]  w_edge_next;
    logic [DATA_W-1:0]   r_tx_shift;
    logic [DATA_W-1:0]   r_rx_shift;
    logic [DATA_W-1:0]   r_rx_data;
    logic                w_last;
    logic                w_sample;
    logic                w_lsb_first;
    logic                w_start_lsb;

`ifdef SPI_LSB_FIRST_EN
    logic r_lsb_first;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lsb_first <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_lsb_first <= lsbFirst;
        end
    end

    assign w_lsb_first = r_lsb_first;
    assign w_start_lsb = lsbFirst;
`else
    assign w_lsb_first = 1'b0;
    assign w_start_lsb = 1'b0;
`endif

    function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    assign w_edge_next = r_edge_cnt + c_CNT_W'(1);
    assign w_last      = (w_edge_next == c_LAST_EDGE);
    // Odd edges sample in phase 0, even edges sample in phase 1.
    assign w_sample    = w_edge_next[0] ^ r_cpha;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // CS_n drops already in the accepting IDLE cycle, so back-to-back frames
    // are separated only by the single FINISH cycle.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        CS_n         = 1'b1;
        prescaleEn   = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = LEAD;
                    CS_n         = 1'b0;
                end
            end
            LEAD: begin
                busy       = 1'b1;
                CS_n       = 1'b0;
                prescaleEn = 1'b1;
                if (SCLKTick) begin
                    w_next_state = XFER;
                end
            end
            XFER: begin
                busy       = 1'b1;
                CS_n       = 1'b0;
                prescaleEn = 1'b1;
                if (SCLKTick && w_last) begin
                    w_next_state = TRAIL;
                end
            end
            TRAIL: begin
                busy       = 1'b1;
                CS_n       = 1'b0;
                prescaleEn = 1'b1;
                if (SCLKTick) begin
                    w_next_state = FINISH;
                end
            end
            FINISH: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_edge_cnt <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cpol     <= cpol;
                        r_cpha     <= cpha;
                        r_sclk     <= cpol;
                        r_edge_cnt <= '0;
                        r_rx_shift <= '0;
                        // Phase 0 needs the first bit on the wire before the first edge.
                        if (!cpha) begin
                            r_mosi     <= head_bit(txData, w_start_lsb);
                            r_tx_shift <= advance(txData, w_start_lsb);
                        end else begin
                            r_tx_shift <= txData;
                        end
                    end
                end
                XFER: begin
                    if (SCLKTick) begin
                        r_edge_cnt <= w_edge_next;
                        r_sclk     <= w_last ? r_cpol : ~r_sclk;
                        if (w_sample) begin
                            r_rx_shift <= w_lsb_first ? {MISO, r_rx_shift[DATA_W-1:1]}
                                                      : {r_rx_shift[DATA_W-2:0], MISO};
                        end else if (!w_last) begin
                            r_mosi     <= head_bit(r_tx_shift, w_lsb_first);
                            r_tx_shift <= advance(r_tx_shift, w_lsb_first);
                        end
                    end
                end
                TRAIL: begin
                    if (SCLKTick) begin
                        r_rx_data <= r_rx_shift;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign SCLK   = r_sclk;
    assign MOSI   = r_mosi;
    assign rxData = r_rx_data;

endmodule
`default_nettype wire
